// File: rtl/trap_shaper_filter.sv
// Trapezoidal shaper: x delay line, pole-zero corrected Jordanov recursion, 5-stage pipeline.
// Define TRAP_SHAPER_PEAK_DETECT_EN to build the peak FSM; otherwise peak outputs are tied to 0.
module trap_shaper_filter #(
   parameter int unsigned IN_WIDTH  = 12,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned ACC_WIDTH = 32,
   parameter int unsigned K_DELAY   = 16,
   parameter int unsigned L_DELAY   = 32,
   parameter int unsigned M_WIDTH   = 16,
   parameter int unsigned SHIFT     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        input_valid,
   input  logic [IN_WIDTH-1:0]         input_data,
   input  logic [M_WIDTH-1:0]          pz_m,
   input  logic [1:0]                  mode,
   input  logic signed [OUT_WIDTH-1:0] threshold,
   output logic                        output_valid,
   output logic signed [OUT_WIDTH-1:0] output_data,
   output logic                        peak_valid,
   output logic signed [OUT_WIDTH-1:0] peak_value
);
   localparam int unsigned DWidth = IN_WIDTH + 3;
   localparam int unsigned Depth  = K_DELAY + L_DELAY;
   localparam logic signed [ACC_WIDTH-1:0] OutMax =
      $signed({{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
   localparam logic signed [ACC_WIDTH-1:0] OutMin =
      $signed({{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

   // v_q[0] is the input register, v_q[5] is output_valid.
   logic [5:0]                  v_q, v_d;
   logic [IN_WIDTH-1:0]         x_q, x_d, x1_q, x1_d, x2_q, x2_d, x3_q, x3_d, x4_q, x4_d;
   logic [IN_WIDTH-1:0]         dl_q [Depth];
   logic [IN_WIDTH-1:0]         dl_d [Depth];
   logic signed [DWidth-1:0]    d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
   logic signed [ACC_WIDTH-1:0] p_q, p_d, p3_q, p3_d, p4_q, p4_d, r_q, r_d, s_q, s_d;
   logic signed [OUT_WIDTH-1:0] out_q, out_d;
   logic signed [ACC_WIDTH-1:0] d1_ext, d2_ext, d4_ext, m_ext, sel;

   assign d1_ext = {{(ACC_WIDTH-DWidth){d1_q[DWidth-1]}}, d1_q};
   assign d2_ext = {{(ACC_WIDTH-DWidth){d2_q[DWidth-1]}}, d2_q};
   assign d4_ext = {{(ACC_WIDTH-DWidth){d4_q[DWidth-1]}}, d4_q};
   assign m_ext  = $signed({{(ACC_WIDTH-M_WIDTH){1'b0}}, pz_m});

   always_comb begin
      v_d  = {v_q[4:0], input_valid};
      x_d  = x_q;
      dl_d = dl_q;
      d1_d = d1_q;  x1_d = x1_q;
      p_d  = p_q;   d2_d = d2_q;  x2_d = x2_q;
      r_d  = r_q;   p3_d = p3_q;  d3_d = d3_q;  x3_d = x3_q;
      s_d  = s_q;   p4_d = p4_q;  d4_d = d4_q;  x4_d = x4_q;
      if (input_valid) x_d = input_data;
      // dl_q[i] holds x[n-1-i] relative to the sample sitting in x_q.
      if (v_q[0]) begin
         dl_d[0] = x_q;
         for (int i = 1; i < Depth; i++) dl_d[i] = dl_q[i-1];
         d1_d = $signed({3'b000, x_q}) - $signed({3'b000, dl_q[K_DELAY-1]})
              - $signed({3'b000, dl_q[L_DELAY-1]}) + $signed({3'b000, dl_q[Depth-1]});
         x1_d = x_q;
      end
      if (v_q[1]) begin
         p_d  = p_q + d1_ext;
         d2_d = d1_q;
         x2_d = x1_q;
      end
      if (v_q[2]) begin
         r_d  = p_q + m_ext * d2_ext;
         p3_d = p_q;
         d3_d = d2_q;
         x3_d = x2_q;
      end
      if (v_q[3]) begin
         s_d  = s_q + r_q;
         p4_d = p3_q;
         d4_d = d3_q;
         x4_d = x3_q;
      end
   end

   always_comb begin
      case (mode)
         2'd0:    sel = s_q >>> SHIFT;
         2'd1:    sel = $signed({{(ACC_WIDTH-IN_WIDTH){1'b0}}, x4_q});
         2'd2:    sel = d4_ext;
         default: sel = p4_q;
      endcase
      out_d = out_q;
      if (v_q[4]) begin
         if (sel > OutMax)      out_d = OutMax[OUT_WIDTH-1:0];
         else if (sel < OutMin) out_d = OutMin[OUT_WIDTH-1:0];
         else                   out_d = sel[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q  <= '0;
         x_q  <= '0;
         for (int i = 0; i < Depth; i++) dl_q[i] <= '0;
         d1_q <= '0;  x1_q <= '0;
         p_q  <= '0;  d2_q <= '0;  x2_q <= '0;
         r_q  <= '0;  p3_q <= '0;  d3_q <= '0;  x3_q <= '0;
         s_q  <= '0;  p4_q <= '0;  d4_q <= '0;  x4_q <= '0;
         out_q <= '0;
      end else begin
         v_q  <= v_d;
         x_q  <= x_d;
         dl_q <= dl_d;
         d1_q <= d1_d;  x1_q <= x1_d;
         p_q  <= p_d;   d2_q <= d2_d;  x2_q <= x2_d;
         r_q  <= r_d;   p3_q <= p3_d;  d3_q <= d3_d;  x3_q <= x3_d;
         s_q  <= s_d;   p4_q <= p4_d;  d4_q <= d4_d;  x4_q <= x4_d;
         out_q <= out_d;
      end
   end

   assign output_valid = v_q[5];
   assign output_data  = out_q;

`ifdef TRAP_SHAPER_PEAK_DETECT_EN
   typedef enum logic {StIdle, StAbove} state_e;
   state_e                      state_q, state_d;
   logic signed [OUT_WIDTH-1:0] max_q, max_d, peak_value_q, peak_value_d;
   logic                        peak_valid_q, peak_valid_d;

   always_comb begin
      state_d      = state_q;
      max_d        = max_q;
      peak_value_d = peak_value_q;
      peak_valid_d = 1'b0;
      if (v_q[5]) begin
         case (state_q)
            StIdle: begin
               if (out_q > threshold) begin
                  state_d = StAbove;
                  max_d   = out_q;
               end
            end
            StAbove: begin
               if (out_q <= threshold) begin
                  state_d      = StIdle;
                  peak_valid_d = 1'b1;
                  peak_value_d = max_q;
               end else if (out_q > max_q) begin
                  max_d = out_q;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         max_q        <= '0;
         peak_value_q <= '0;
         peak_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         max_q        <= max_d;
         peak_value_q <= peak_value_d;
         peak_valid_q <= peak_valid_d;
      end
   end

   assign peak_valid = peak_valid_q;
   assign peak_value = peak_value_q;
`else
   logic unused_threshold;
   assign unused_threshold = ^threshold;
   assign peak_valid = 1'b0;
   assign peak_value = '0;
`endif

endmodule

// File: tb/tb_trap_shaper_filter.sv
// Directed bench for trap_shaper_filter: impulse/step shapes per mode, pole-zero, bubbles,
// saturation and mid-pulse reset. Peak strobe expectations follow TRAP_SHAPER_PEAK_DETECT_EN.
module tb_trap_shaper_filter;
   logic               clk = 1'b0;
   logic               reset;
   logic               input_valid;
   logic [11:0]        input_data;
   logic [15:0]        pz_m;
   logic [1:0]         mode;
   logic signed [15:0] threshold;
   logic               output_valid, peak_valid;
   logic signed [15:0] output_data, peak_value;
   logic               sat_valid, sat_peak_valid;
   logic signed [15:0] sat_data, sat_peak_value;

   int n_checks = 0;
   int n_errors = 0;
   int exp_tab [0:15];

`ifdef TRAP_SHAPER_PEAK_DETECT_EN
   localparam bit PeakEn = 1'b1;
`else
   localparam bit PeakEn = 1'b0;
`endif

   trap_shaper_filter #(
      .IN_WIDTH(12), .OUT_WIDTH(16), .ACC_WIDTH(32), .K_DELAY(4), .L_DELAY(8),
      .M_WIDTH(16), .SHIFT(0)
   ) dut (
      .clk(clk), .reset(reset), .input_valid(input_valid), .input_data(input_data),
      .pz_m(pz_m), .mode(mode), .threshold(threshold), .output_valid(output_valid),
      .output_data(output_data), .peak_valid(peak_valid), .peak_value(peak_value)
   );

   trap_shaper_filter #(
      .IN_WIDTH(12), .OUT_WIDTH(16), .ACC_WIDTH(32), .K_DELAY(16), .L_DELAY(32),
      .M_WIDTH(16), .SHIFT(0)
   ) dut_sat (
      .clk(clk), .reset(reset), .input_valid(input_valid), .input_data(input_data),
      .pz_m(pz_m), .mode(mode), .threshold(threshold), .output_valid(sat_valid),
      .output_data(sat_data), .peak_valid(sat_peak_valid), .peak_value(sat_peak_value)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input bit v, input int x);
      input_valid = v;
      input_data  = 12'(x);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      input_valid = 1'b0;
      input_data  = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Continuous-valid run; exp_tab holds the expected output from 5 clocks after the first sample.
   task automatic run_case(input string tag, input int amp, input bit step, input int n_exp,
                           input int strobe_t, input int strobe_v);
      do_reset();
      for (int t = 0; t < n_exp + 5; t++) begin
         tick(1'b1, (t == 0 || step) ? amp : 0);
         if (t < 5) begin
            check_eq($sformatf("%s valid t=%0d", tag, t), output_valid, 0);
         end else begin
            check_eq($sformatf("%s valid t=%0d", tag, t), output_valid, 1);
            check_eq($sformatf("%s data t=%0d", tag, t), output_data, exp_tab[t-5]);
         end
         check_eq($sformatf("%s peak_valid t=%0d", tag, t), peak_valid,
                  (PeakEn && t == strobe_t) ? 1 : 0);
      end
      check_eq($sformatf("%s peak_value", tag), peak_value,
               (PeakEn && strobe_t >= 0) ? strobe_v : 0);
   endtask

   task automatic run_bubbles();
      do_reset();
      for (int t = 0; t < 31; t++) begin
         tick(t % 2 == 0, (t == 0) ? 100 : 0);
         if (t < 5) begin
            check_eq($sformatf("bub valid t=%0d", t), output_valid, 0);
         end else if ((t - 5) % 2 == 0) begin
            check_eq($sformatf("bub valid t=%0d", t), output_valid, 1);
            check_eq($sformatf("bub data t=%0d", t), output_data, exp_tab[(t-5)/2]);
         end else begin
            check_eq($sformatf("bub valid t=%0d", t), output_valid, 0);
            check_eq($sformatf("bub hold t=%0d", t), output_data, exp_tab[(t-6)/2]);
         end
         check_eq($sformatf("bub peak_valid t=%0d", t), peak_valid,
                  (PeakEn && t == 24) ? 1 : 0);
      end
   endtask

   // K=16, L=32: s = 4095 * triangle-ish ramp, clamped at 32767.
   task automatic run_saturation();
      int n, tri_v, e;
      do_reset();
      for (int t = 0; t < 55; t++) begin
         tick(1'b1, (t == 0) ? 4095 : 0);
         if (t >= 5) begin
            n = t - 5;
            if (n < 16)      tri_v = n + 1;
            else if (n < 32) tri_v = 16;
            else if (n < 48) tri_v = 47 - n;
            else             tri_v = 0;
            e = 4095 * tri_v;
            if (e > 32767) e = 32767;
            check_eq($sformatf("sat data n=%0d", n), sat_data, e);
         end
      end
   endtask

   task automatic run_mid_reset();
      do_reset();
      for (int t = 0; t < 9; t++) tick(1'b1, (t == 0) ? 100 : 0);
      check_eq("mid flat top", output_data, 400);
      reset = 1'b1;
      #1;
      check_eq("mid rst valid", output_valid, 0);
      check_eq("mid rst data", output_data, 0);
      check_eq("mid rst peak_valid", peak_valid, 0);
      check_eq("mid rst peak_value", peak_value, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int t = 0; t < 20; t++) begin
         tick(1'b1, 0);
         check_eq($sformatf("post rst data t=%0d", t), output_data, 0);
         check_eq($sformatf("post rst peak_valid t=%0d", t), peak_valid, 0);
      end
   endtask

   initial begin
      reset       = 1'b1;
      input_valid = 1'b0;
      input_data  = '0;
      pz_m        = '0;
      mode        = 2'd0;
      threshold   = 16'sd200;
      do_reset();
      check_eq("rst valid", output_valid, 0);
      check_eq("rst data", output_data, 0);
      check_eq("rst peak_valid", peak_valid, 0);
      check_eq("rst peak_value", peak_value, 0);

      exp_tab = '{100, 200, 300, 400, 400, 400, 400, 400, 300, 200, 100, 0, 0, 0, 0, 0};
      run_case("imp_s", 100, 1'b0, 13, 15, 400);
      mode = 2'd3;
      run_case("step_p", 100, 1'b1, 13, 15, 400);
      mode = 2'd2;
      exp_tab = '{100, 0, 0, 0, -100, 0, 0, 0, -100, 0, 0, 0, 100, 0, 0, 0};
      run_case("imp_d", 100, 1'b0, 13, -1, 0);
      mode = 2'd1;
      exp_tab = '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      run_case("imp_x", 100, 1'b0, 13, -1, 0);
      mode = 2'd0;
      pz_m = 16'd1;
      exp_tab = '{200, 300, 400, 500, 400, 400, 400, 400, 200, 100, 0, -100, 0, 0, 0, 0};
      run_case("pz1", 100, 1'b0, 13, 14, 500);
      pz_m = 16'd0;
      exp_tab = '{100, 200, 300, 400, 400, 400, 400, 400, 300, 200, 100, 0, 0, 0, 0, 0};
      run_bubbles();
      run_saturation();
      run_mid_reset();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
